regfile_preloader: RTL
======================

Name: regfile_preloader

Overview:
- Hardware writer for the register file's write port.
- On a start pulse it holds the processor in reset and takes a valid/ready stream of 32-bit words. It writes them into consecutive registers FIRST_REG..LAST_REG, then releases the processor.
- Sits between processor and my_regfile. Outside a load it passes the processor's write port through unchanged.
- Used to seed register state before a program runs, on board or in bench.

Parameters:
- FIRST_REG, 1, first register written; must be 1..31. Register 0 is never written.
- LAST_REG, 31, last register written; must satisfy FIRST_REG <= LAST_REG <= 31.
- RELEASE_DELAY, 2, cycles cpu_hold stays high after the last write (1..15).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- in_valid  in  1  input word valid.
- in_data  in  32  word for the current target register.
- in_ready  out  1  preloader accepts in_data this cycle.
- cpu_rwe  in  1  processor ctrl_writeEnable.
- cpu_rd  in  5  processor ctrl_writeReg.
- cpu_rdata  in  32  processor data_writeReg.
- rf_we  out  1  regfile ctrl_writeEnable.
- rf_rd  out  5  regfile ctrl_writeReg.
- rf_data  out  32  regfile data_writeReg.
- cpu_hold  out  1  ORed into the processor reset by the top level.
- busy  out  1  high in HOLD, LOAD and RELEASE.
- done  out  1  high in DONE.
- loaded_count  out  6  number of words written in the current or last load.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, ptr=FIRST_REG, loaded_count=0, release counter=0, cpu_hold=0, busy=0, done=0, in_ready=0.
- Reset takes priority over every other input, including mid-load; a partial load is abandoned and nothing is retried.
- States and transitions:
  - IDLE: start -> HOLD.
  - HOLD: exactly 1 cycle, cpu_hold=1, no writes -> LOAD. On entry ptr=FIRST_REG and loaded_count=0.
  - LOAD: in_ready=1. Each handshake (in_valid & in_ready) writes the word. If the handshake occurs with ptr==LAST_REG -> RELEASE; otherwise ptr += 1. Counter loaded_count increments on each handshake.
  - RELEASE: cpu_hold=1, in_ready=0. Counter counts RELEASE_DELAY cycles, then -> DONE.
  - DONE: done=1, cpu_hold=0; passthrough active; start -> HOLD, which clears loaded_count.
- Signal rules:
  - start is ignored in HOLD, LOAD and RELEASE.
  - in_ready is combinational from state: 1 only in LOAD.
  - in_valid with no handshake (outside LOAD) has no effect. A stalled stream (in_valid=0) holds LOAD indefinitely with cpu_hold=1.
- Write-port mux, combinational:
  - IDLE/DONE: rf_we=cpu_rwe, rf_rd=cpu_rd, rf_data=cpu_rdata.
  - HOLD/LOAD/RELEASE: rf_we=in_valid&in_ready, rf_rd=ptr, rf_data=in_data. All processor writes are dropped.
  - Write latency is zero: the word lands in the regfile on the same posedge as the handshake.
- cpu_hold is registered: high on the first cycle of HOLD, low on the first DONE cycle.
- Total load length for N=LAST_REG-FIRST_REG+1 words with in_valid held high: 1 + N + RELEASE_DELAY cycles from start to done.

Optional Feature:
- Macro: PRELOAD_CHECKSUM_EN.
- When defined:
  - Extra output port checksum, out, 32 bits: the wrapping 32-bit sum of all words accepted in the current load.
  - checksum clears on HOLD entry and on reset, and holds its value through DONE.
- When undefined: the checksum port and adder are absent; behaviour is otherwise identical.

Test Plan:
- Reset check: reset high for 2 cycles, then start, in_valid=1, in_data=k*3 for k=1..31 -> regs 1..31 read k*3, reg 0 reads 0, loaded_count=31, done after 1+31+2=34 cycles.
- Passthrough: in IDLE drive cpu_rwe=1, cpu_rd=5, cpu_rdata=0xDEADBEEF -> rf_* mirror the inputs and reg 5 = 0xDEADBEEF. Repeat during LOAD -> write dropped, reg 5 keeps the preloaded value.
- Backpressure: toggle in_valid 1,0,0,1 per word with FIRST_REG=4, LAST_REG=6 and words 10,20,30 -> regs 4/5/6 = 10/20/30, cpu_hold high throughout, ptr never skips.
- start ignored: pulse start mid-LOAD -> ptr and loaded_count unchanged, no restart. Pulse start in DONE -> new load overwrites regs, loaded_count restarts at 0.
- Reset mid-operation: assert reset after 7 words -> next cycle state IDLE, cpu_hold=0, in_ready=0, regs 1..7 retain the loaded values.
- Checksum (with PRELOAD_CHECKSUM_EN): 31 words of 0xFFFFFFFF -> checksum = 0xFFFFFFE1 (wraps); a second load of all 1 -> checksum = 31.

Source files
------------

// File: rtl/regfile_preloader.sv
// Register-file preloader: streams words into FIRST_REG..LAST_REG while holding the CPU.
// Optional running checksum of accepted words when PRELOAD_CHECKSUM_EN is defined.
module regfile_preloader #(
   parameter int unsigned FIRST_REG     = 1,
   parameter int unsigned LAST_REG      = 31,
   parameter int unsigned RELEASE_DELAY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        in_ready,
   input  logic        cpu_rwe,
   input  logic [4:0]  cpu_rd,
   input  logic [31:0] cpu_rdata,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_data,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic [5:0]  loaded_count
`ifdef PRELOAD_CHECKSUM_EN
   ,
   output logic [31:0] checksum
`endif
);

   localparam logic [4:0] FIRST   = 5'(FIRST_REG);
   localparam logic [4:0] LAST    = 5'(LAST_REG);
   localparam logic [3:0] REL_END = 4'(RELEASE_DELAY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOLD,
      S_LOAD,
      S_RELEASE,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  ptr_q, ptr_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [3:0]  rel_q, rel_d;
   logic        hold_q, hold_d;
   logic        fire;
   logic        go;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      rel_d    = rel_q;
      in_ready = (state_q == S_LOAD);
      busy     = (state_q == S_HOLD) || (state_q == S_LOAD)
              || (state_q == S_RELEASE);
      done     = (state_q == S_DONE);
      fire     = in_valid & in_ready;
      go       = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               go      = 1'b1;
               state_d = S_HOLD;
               ptr_d   = FIRST;
               cnt_d   = '0;
            end
         end
         S_HOLD: state_d = S_LOAD;
         S_LOAD: begin
            if (fire) begin
               cnt_d = cnt_q + 6'd1;
               if (ptr_q == LAST) begin
                  state_d = S_RELEASE;
                  rel_d   = '0;
               end else begin
                  ptr_d = ptr_q + 5'd1;
               end
            end
         end
         S_RELEASE: begin
            if (rel_q == REL_END) state_d = S_DONE;
            else                  rel_d   = rel_q + 4'd1;
         end
         default: state_d = S_IDLE;
      endcase
      hold_d = (state_d == S_HOLD) || (state_d == S_LOAD)
            || (state_d == S_RELEASE);
   end

   // Processor writes are dropped for the whole hold window, not just LOAD.
   always_comb begin
      rf_we   = cpu_rwe;
      rf_rd   = cpu_rd;
      rf_data = cpu_rdata;
      if (busy) begin
         rf_we   = fire;
         rf_rd   = ptr_q;
         rf_data = in_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= FIRST;
         cnt_q   <= '0;
         rel_q   <= '0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         rel_q   <= rel_d;
         hold_q  <= hold_d;
      end
   end

   assign cpu_hold     = hold_q;
   assign loaded_count = cnt_q;

`ifdef PRELOAD_CHECKSUM_EN
   logic [31:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (go)        sum_d = '0;
      else if (fire) sum_d = sum_q + in_data;
   end

   always_ff @(posedge clock) begin
      if (reset) sum_q <= '0;
      else       sum_q <= sum_d;
   end

   assign checksum = sum_q;
`endif

endmodule
